serial_bus_arbiter: RTL and testbench
=====================================

SERIAL_BUS_ARBITER -- requirements
Module: serial_bus_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter NUM_CLIENTS, default 2: number of requesters sharing one serial bus master, range 2..8.
REQ-003 Parameter BUS_BITS, default 16: serial word width.
REQ-004 Parameter SETUP_CYCLES, default 2: cycles that chip select is held before enable is forwarded.
REQ-005 Parameter GUARD_CYCLES, default 4: idle cycles after a release before the next grant.
REQ-006 in_clk  input  1  system clock.
REQ-007 in_rst  input  1  asynchronous reset, active-low (0 = reset).
REQ-008 in_cl_select  input  NUM_CLIENTS  per-client chip-select request; held high for the whole transaction.
REQ-009 in_cl_enable  input  NUM_CLIENTS  per-client word-transfer enable.
REQ-010 in_cl_data  input  NUM_CLIENTS*BUS_BITS  per-client word; client i occupies bits [i*BUS_BITS +: BUS_BITS].
REQ-011 out_cl_ready  output  NUM_CLIENTS  bus-ready returned to each client.
REQ-012 out_cl_next_word  output  NUM_CLIENTS  next-word strobe returned to each client.
REQ-013 out_cl_grant  output  NUM_CLIENTS  one-hot current grant, status only.
REQ-014 in_bus_ready  input  1  master ready.
REQ-015 in_bus_next_word  input  1  master next-word strobe.
REQ-016 out_bus_enable  output  1  enable to master.
REQ-017 out_bus_data  output  BUS_BITS  word to master.
REQ-018 out_bus_select  output  NUM_CLIENTS  per-device chip select.

Function
REQ-019 FSM states SHALL be Idle, Setup, Owned, Drain and Guard, with the state and the grant vector registered.
REQ-020 Idle: if any in_cl_select bit is high, the FSM SHALL pick the winner round-robin, register a one-hot grant and enter Setup on the next edge, so the grant appears 1 cycle after the request.
REQ-021 Round-robin rule: search starts at index ptr and wraps modulo NUM_CLIENTS; after granting client i, ptr becomes (i+1) mod NUM_CLIENTS; ptr is 0 after reset.
REQ-022 Setup: out_bus_select[g] SHALL be 1 and out_bus_enable SHALL be 0; after SETUP_CYCLES cycles the FSM SHALL enter Owned.
REQ-023 Owned (combinational pass-through, no added latency):
  - out_bus_select[g] = in_cl_select[g]
  - out_bus_enable = in_cl_enable[g]
  - out_bus_data = word g
  - out_cl_ready[g] = in_bus_ready
  - out_cl_next_word[g] = in_bus_next_word
REQ-024 Non-granted clients SHALL see out_cl_ready = 0 and out_cl_next_word = 0 at all times, and their select and enable SHALL never reach the master.
REQ-025 Outside Owned, out_bus_enable SHALL be 0 and out_bus_data SHALL be all zeros.
REQ-026 Release: when in_cl_select[g] falls in Owned, the FSM SHALL enter Drain.
REQ-027 Drain: select SHALL be 0; the FSM SHALL wait for in_bus_ready = 1, then enter Guard.
REQ-028 Guard: all selects SHALL be 0 for GUARD_CYCLES cycles; the grant SHALL then clear and the FSM SHALL enter Idle.
REQ-029 A client that drops select during Setup SHALL go directly to Guard.
REQ-030 An in_cl_enable pulse with select low SHALL be ignored.
REQ-031 Simultaneous requests SHALL be resolved only by ptr.
REQ-032 A new request arriving during Setup, Owned, Drain or Guard SHALL wait; it SHALL never pre-empt the current owner.
REQ-033 Cycle counters SHALL be sized as $clog2(max(SETUP_CYCLES, GUARD_CYCLES)) + 1 bits and SHALL reset to 0 on each state entry.
REQ-034 An illegal state SHALL return to Idle with the grant cleared.

Reset
REQ-035 With in_rst = 0, asynchronously: state = Idle, grant = 0, ptr = 0, counters = 0, and all outputs = 0.
REQ-036 Reset asserted mid-transaction SHALL drop every select within the same cycle; after release, arbitration SHALL restart from client 0.

Structure
REQ-037 Package serial_arb_pkg SHALL hold the t_arb_state enum and the default SETUP and GUARD constants.
REQ-038 Sub-module rr_select (combinational: request vector + ptr -> one-hot winner) SHALL be instantiated once.

Verification
REQ-039 Single client: client 0 requests, one 16-bit word 16'h0C01 -> grant in 1 cycle; select[0] rises; enable is forwarded after 2 cycles; master sees 16'h0C01; Guard lasts 4 cycles.
REQ-040 Simultaneous requests from clients 0 and 1 after reset -> client 0 served first, then client 1 after Guard; ptr = 0 at the end.
REQ-041 Client 1 requests while client 0 owns the bus, sending 8 words -> client 1 sees ready = 0 and next_word = 0 throughout; out_bus_select[1] stays 0 until client 0 has released and Guard has elapsed.
REQ-042 Client drops select while in_bus_ready = 0 -> FSM holds Drain until in_bus_ready = 1, then Guard.
REQ-043 Reset pulse in mid-word of client 1 -> all outputs 0 in the same cycle; next simultaneous request is granted to client 0.
REQ-044 Client 1 pulses enable with select low -> out_bus_enable stays 0.

Source files
------------

// File: rtl/serial_arb_pkg.sv
// Shared types and defaults for the serial bus arbiter.
package serial_arb_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSetup = 3'd1,
    StOwned = 3'd2,
    StDrain = 3'd3,
    StGuard = 3'd4
  } t_arb_state;

  localparam int unsigned DefSetupCycles = 2;
  localparam int unsigned DefGuardCycles = 4;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping to 0.
module rr_select #(
  parameter int unsigned NUM_CLIENTS = 2,
  parameter int unsigned PTR_W       = 1
) (
  input  logic [NUM_CLIENTS-1:0] in_req,
  input  logic [PTR_W-1:0]       in_ptr,
  output logic [NUM_CLIENTS-1:0] out_onehot,
  output logic [PTR_W-1:0]       out_idx,
  output logic                   out_valid
);

  always_comb begin
    out_onehot = '0;
    out_idx    = '0;
    out_valid  = 1'b0;
    // First pass covers ptr..N-1; the second pass only fires when that range is empty.
    for (int i = 0; i < int'(NUM_CLIENTS); i++) begin
      if (!out_valid && in_req[i] && (i >= int'(in_ptr))) begin
        out_valid     = 1'b1;
        out_onehot[i] = 1'b1;
        out_idx       = PTR_W'(i);
      end
    end
    for (int i = 0; i < int'(NUM_CLIENTS); i++) begin
      if (!out_valid && in_req[i]) begin
        out_valid     = 1'b1;
        out_onehot[i] = 1'b1;
        out_idx       = PTR_W'(i);
      end
    end
  end

endmodule

// File: rtl/serial_bus_arbiter.sv
// Shares one serial bus master between NUM_CLIENTS requesters with a
// setup / owned / drain / guard handshake around every grant.
module serial_bus_arbiter
  import serial_arb_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS  = 2,
  parameter int unsigned BUS_BITS     = 16,
  parameter int unsigned SETUP_CYCLES = DefSetupCycles,
  parameter int unsigned GUARD_CYCLES = DefGuardCycles
) (
  input  logic                          in_clk,
  input  logic                          in_rst,
  input  logic [NUM_CLIENTS-1:0]        in_cl_select,
  input  logic [NUM_CLIENTS-1:0]        in_cl_enable,
  input  logic [NUM_CLIENTS*BUS_BITS-1:0] in_cl_data,
  output logic [NUM_CLIENTS-1:0]        out_cl_ready,
  output logic [NUM_CLIENTS-1:0]        out_cl_next_word,
  output logic [NUM_CLIENTS-1:0]        out_cl_grant,
  input  logic                          in_bus_ready,
  input  logic                          in_bus_next_word,
  output logic                          out_bus_enable,
  output logic [BUS_BITS-1:0]           out_bus_data,
  output logic [NUM_CLIENTS-1:0]        out_bus_select
);

  localparam int unsigned PtrW = $clog2(NUM_CLIENTS);
  localparam int unsigned CntW = $clog2(max_u(SETUP_CYCLES, GUARD_CYCLES)) + 1;

  t_arb_state             r_state, w_state_next;
  logic [NUM_CLIENTS-1:0] r_grant, w_grant_next;
  logic [PtrW-1:0]        r_ptr, w_ptr_next;
  logic [CntW-1:0]        r_cnt, w_cnt_next;

  logic [NUM_CLIENTS-1:0] w_win_onehot;
  logic [PtrW-1:0]        w_win_idx;
  logic                   w_win_valid;
  logic                   w_owner_sel;

  rr_select #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .PTR_W       (PtrW)
  ) u_rr_select (
    .in_req     (in_cl_select),
    .in_ptr     (r_ptr),
    .out_onehot (w_win_onehot),
    .out_idx    (w_win_idx),
    .out_valid  (w_win_valid)
  );

  assign w_owner_sel = |(in_cl_select & r_grant);

  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    w_ptr_next   = r_ptr;
    w_cnt_next   = r_cnt;
    case (r_state)
      StIdle: begin
        if (w_win_valid) begin
          w_state_next = StSetup;
          w_grant_next = w_win_onehot;
          w_ptr_next   = (w_win_idx == PtrW'(NUM_CLIENTS - 1)) ? '0 : w_win_idx + PtrW'(1);
          w_cnt_next   = '0;
        end
      end
      StSetup: begin
        // An owner abandoning during setup skips drain: nothing reached the master yet.
        if (!w_owner_sel) begin
          w_state_next = StGuard;
          w_cnt_next   = '0;
        end else if (r_cnt == CntW'(SETUP_CYCLES - 1)) begin
          w_state_next = StOwned;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CntW'(1);
        end
      end
      StOwned: begin
        if (!w_owner_sel) begin
          w_state_next = StDrain;
          w_cnt_next   = '0;
        end
      end
      StDrain: begin
        if (in_bus_ready) begin
          w_state_next = StGuard;
          w_cnt_next   = '0;
        end
      end
      StGuard: begin
        if (r_cnt == CntW'(GUARD_CYCLES - 1)) begin
          w_state_next = StIdle;
          w_grant_next = '0;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CntW'(1);
        end
      end
      default: begin
        w_state_next = StIdle;
        w_grant_next = '0;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      r_state <= StIdle;
      r_grant <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_grant <= w_grant_next;
      r_ptr   <= w_ptr_next;
      r_cnt   <= w_cnt_next;
    end
  end

  assign out_cl_grant = r_grant;

  always_comb begin
    out_bus_select   = '0;
    out_bus_enable   = 1'b0;
    out_bus_data     = '0;
    out_cl_ready     = '0;
    out_cl_next_word = '0;
    case (r_state)
      StSetup: out_bus_select = r_grant;
      StOwned: begin
        out_bus_select   = in_cl_select & r_grant;
        // Enable with select low is never forwarded.
        out_bus_enable   = |(in_cl_enable & in_cl_select & r_grant);
        out_cl_ready     = r_grant & {NUM_CLIENTS{in_bus_ready}};
        out_cl_next_word = r_grant & {NUM_CLIENTS{in_bus_next_word}};
        for (int i = 0; i < int'(NUM_CLIENTS); i++) begin
          out_bus_data = out_bus_data
                       | (in_cl_data[i*BUS_BITS +: BUS_BITS] & {BUS_BITS{r_grant[i]}});
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Self-checking bench: vector table, directed corner sequences, and random
// stimulus against a transaction-level reference model.
module tb_serial_bus_arbiter;

  localparam int N     = 2;
  localparam int B     = 16;
  localparam int Setup = 2;
  localparam int Guard = 4;

  localparam int PhIdle  = 0;
  localparam int PhSetup = 1;
  localparam int PhOwned = 2;
  localparam int PhDrain = 3;
  localparam int PhGuard = 4;

  logic           in_clk = 1'b0;
  logic           in_rst;
  logic [N-1:0]   in_cl_select;
  logic [N-1:0]   in_cl_enable;
  logic [N*B-1:0] in_cl_data;
  logic           in_bus_ready;
  logic           in_bus_next_word;
  logic [N-1:0]   out_cl_ready;
  logic [N-1:0]   out_cl_next_word;
  logic [N-1:0]   out_cl_grant;
  logic           out_bus_enable;
  logic [B-1:0]   out_bus_data;
  logic [N-1:0]   out_bus_select;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 in_clk = ~in_clk;

  serial_bus_arbiter #(
    .NUM_CLIENTS  (N),
    .BUS_BITS     (B),
    .SETUP_CYCLES (Setup),
    .GUARD_CYCLES (Guard)
  ) dut (
    .in_clk           (in_clk),
    .in_rst           (in_rst),
    .in_cl_select     (in_cl_select),
    .in_cl_enable     (in_cl_enable),
    .in_cl_data       (in_cl_data),
    .out_cl_ready     (out_cl_ready),
    .out_cl_next_word (out_cl_next_word),
    .out_cl_grant     (out_cl_grant),
    .in_bus_ready     (in_bus_ready),
    .in_bus_next_word (in_bus_next_word),
    .out_bus_enable   (out_bus_enable),
    .out_bus_data     (out_bus_data),
    .out_bus_select   (out_bus_select)
  );

  typedef struct packed {
    logic [1:0]  sel;
    logic [1:0]  en;
    logic [31:0] data;
    logic        br;
    logic        nw;
    logic [1:0]  grant;
    logic [1:0]  bsel;
    logic        ben;
    logic [15:0] bdata;
    logic [1:0]  rdy;
    logic [1:0]  nxt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [1:0] grant, input logic [1:0] bsel,
                          input logic ben, input logic [15:0] bdata, input logic [1:0] rdy,
                          input logic [1:0] nxt);
    chk({tag, ".grant"}, 32'(out_cl_grant), 32'(grant));
    chk({tag, ".bus_select"}, 32'(out_bus_select), 32'(bsel));
    chk({tag, ".bus_enable"}, 32'(out_bus_enable), 32'(ben));
    chk({tag, ".bus_data"}, 32'(out_bus_data), 32'(bdata));
    chk({tag, ".cl_ready"}, 32'(out_cl_ready), 32'(rdy));
    chk({tag, ".cl_next_word"}, 32'(out_cl_next_word), 32'(nxt));
  endtask

  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] sel, input logic [1:0] en, input logic [31:0] data,
                       input logic br, input logic nw);
    in_cl_select     = sel;
    in_cl_enable     = en;
    in_cl_data       = data;
    in_bus_ready     = br;
    in_bus_next_word = nw;
  endtask

  task automatic do_reset();
    in_rst = 1'b0;
    drive(2'b00, 2'b00, 32'h0, 1'b1, 1'b0);
    #1;
    chk_outs("reset", 2'b00, 2'b00, 1'b0, 16'h0, 2'b00, 2'b00);
    step();
    step();
    in_rst = 1'b1;
  endtask

  // Reference model: who owns the bus, which phase, and how many cycles remain.
  int m_phase, m_owner, m_left, m_ptr;
  logic [1:0]  e_grant, e_bsel, e_rdy, e_nxt;
  logic        e_en;
  logic [15:0] e_data;

  function automatic bit req(input int c);
    return ((in_cl_select >> c) & 2'b01) != 2'b00;
  endfunction

  task automatic model_expect();
    e_grant = 2'b00; e_bsel = 2'b00; e_rdy = 2'b00; e_nxt = 2'b00; e_en = 1'b0; e_data = 16'h0;
    if (m_owner >= 0) begin
      e_grant = 2'b01 << m_owner;
      if (m_phase == PhSetup) e_bsel = e_grant;
      if (m_phase == PhOwned) begin
        if (req(m_owner)) e_bsel = e_grant;
        e_en   = req(m_owner) && (((in_cl_enable >> m_owner) & 2'b01) != 2'b00);
        e_data = 16'(in_cl_data >> (m_owner * B));
        if (in_bus_ready) e_rdy = e_grant;
        if (in_bus_next_word) e_nxt = e_grant;
      end
    end
  endtask

  task automatic model_step();
    case (m_phase)
      PhIdle: begin
        for (int k = 0; k < N; k++) begin
          if (m_phase == PhIdle && req((m_ptr + k) % N)) begin
            m_owner = (m_ptr + k) % N;
            m_ptr   = (m_owner + 1) % N;
            m_phase = PhSetup;
            m_left  = Setup;
          end
        end
      end
      PhSetup: begin
        if (!req(m_owner)) begin
          m_phase = PhGuard;
          m_left  = Guard;
        end else begin
          m_left--;
          if (m_left == 0) m_phase = PhOwned;
        end
      end
      PhOwned: if (!req(m_owner)) m_phase = PhDrain;
      PhDrain: if (in_bus_ready) begin
        m_phase = PhGuard;
        m_left  = Guard;
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          m_phase = PhIdle;
          m_owner = -1;
        end
      end
    endcase
  endtask

  vec_t vecs [14];
  logic [1:0] r_sel;

  initial begin
    // Single client 0 word, then Guard; client 1 enable with select low is ignored.
    vecs[0]  = {2'b01, 2'b00, 32'hBEEF0C01, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 16'h0000, 2'b00, 2'b00};
    vecs[1]  = {2'b01, 2'b00, 32'hBEEF0C01, 1'b1, 1'b0, 2'b01, 2'b01, 1'b0, 16'h0000, 2'b00, 2'b00};
    vecs[2]  = {2'b01, 2'b01, 32'hBEEF0C01, 1'b1, 1'b0, 2'b01, 2'b01, 1'b0, 16'h0000, 2'b00, 2'b00};
    vecs[3]  = {2'b01, 2'b11, 32'hBEEF0C01, 1'b1, 1'b1, 2'b01, 2'b01, 1'b1, 16'h0C01, 2'b01, 2'b01};
    vecs[4]  = {2'b01, 2'b00, 32'hBEEF0C01, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 16'h0C01, 2'b00, 2'b00};
    vecs[5]  = {2'b00, 2'b00, 32'hBEEF0C01, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 16'h0C01, 2'b01, 2'b00};
    vecs[6]  = {2'b00, 2'b00, 32'hBEEF0C01, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 16'h0000, 2'b00, 2'b00};
    vecs[7]  = {2'b00, 2'b10, 32'hBEEF0C01, 1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 16'h0000, 2'b00, 2'b00};
    vecs[8]  = {2'b00, 2'b10, 32'hBEEF0C01, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 16'h0000, 2'b00, 2'b00};
    vecs[9]  = {2'b00, 2'b10, 32'hBEEF0C01, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 16'h0000, 2'b00, 2'b00};
    vecs[10] = {2'b00, 2'b10, 32'hBEEF0C01, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 16'h0000, 2'b00, 2'b00};
    vecs[11] = {2'b00, 2'b10, 32'hBEEF0C01, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 16'h0000, 2'b00, 2'b00};
    vecs[12] = {2'b10, 2'b00, 32'hBEEF0C01, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 16'h0000, 2'b00, 2'b00};
    vecs[13] = {2'b10, 2'b00, 32'hBEEF0C01, 1'b1, 1'b0, 2'b10, 2'b10, 1'b0, 16'h0000, 2'b00, 2'b00};

    do_reset();
    for (int k = 0; k < 14; k++) begin
      drive(vecs[k].sel, vecs[k].en, vecs[k].data, vecs[k].br, vecs[k].nw);
      #1;
      chk_outs($sformatf("vec%0d", k), vecs[k].grant, vecs[k].bsel, vecs[k].ben,
               vecs[k].bdata, vecs[k].rdy, vecs[k].nxt);
      step();
    end

    // Simultaneous requests: client 0 first, client 1 blocked until Guard ends.
    do_reset();
    drive(2'b11, 2'b00, 32'hBEEF0C01, 1'b1, 1'b0);
    step();
    chk("sim.first_grant", 32'(out_cl_grant), 32'h1);
    step();
    step();
    for (int k = 0; k < 8; k++) begin
      drive(2'b11, 2'b11, {16'hBEEF, 16'(k)}, 1'b1, k[0]);
      #1;
      chk("own.bus_select", 32'(out_bus_select), 32'h1);
      chk("own.bus_data", 32'(out_bus_data), 32'(k));
      chk("own.ready", 32'(out_cl_ready), 32'h1);
      chk("own.next_word", 32'(out_cl_next_word), 32'(k[0]));
      step();
    end
    drive(2'b10, 2'b00, 32'hBEEF0C01, 1'b1, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("wait.bus_select", 32'(out_bus_select), 32'h0);
      chk("wait.grant", 32'(out_cl_grant), (k < 6) ? 32'h1 : 32'h0);
    end
    step();
    chk("sim.second_grant", 32'(out_cl_grant), 32'h2);
    chk("sim.second_select", 32'(out_bus_select), 32'h2);
    step();
    step();
    drive(2'b00, 2'b00, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) step();
    drive(2'b11, 2'b00, 32'h0, 1'b1, 1'b0);
    step();
    chk("sim.ptr_wrapped", 32'(out_cl_grant), 32'h1);

    // Release while master busy: hold Drain until ready.
    do_reset();
    drive(2'b01, 2'b00, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step();
    drive(2'b00, 2'b00, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) step();
    chk("drain.held_grant", 32'(out_cl_grant), 32'h1);
    chk("drain.select", 32'(out_bus_select), 32'h0);
    in_bus_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    chk("drain.guard_last", 32'(out_cl_grant), 32'h1);
    step();
    chk("drain.idle", 32'(out_cl_grant), 32'h0);

    // Drop during Setup goes straight to Guard.
    do_reset();
    drive(2'b01, 2'b00, 32'h0, 1'b1, 1'b0);
    step();
    drive(2'b00, 2'b00, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) step();
    chk("setup_drop.guard", 32'(out_cl_grant), 32'h1);
    step();
    chk("setup_drop.idle", 32'(out_cl_grant), 32'h0);

    // Reset mid-word of client 1.
    do_reset();
    drive(2'b10, 2'b10, 32'hA5A50000, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) step();
    chk("mid.bus_enable", 32'(out_bus_enable), 32'h1);
    chk("mid.bus_data", 32'(out_bus_data), 32'hA5A5);
    #2;
    in_rst = 1'b0;
    #1;
    chk_outs("mid_reset", 2'b00, 2'b00, 1'b0, 16'h0, 2'b00, 2'b00);
    step();
    in_rst = 1'b1;
    drive(2'b11, 2'b00, 32'h0, 1'b1, 1'b0);
    step();
    chk("mid.regrant", 32'(out_cl_grant), 32'h1);

    // Random traffic against the reference model.
    do_reset();
    m_phase = PhIdle;
    m_owner = -1;
    m_left  = 0;
    m_ptr   = 0;
    r_sel   = 2'b00;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) r_sel[i] = ~r_sel[i];
      end
      drive(r_sel, 2'($urandom), $urandom, $urandom_range(0, 3) != 0, 1'($urandom));
      #1;
      model_expect();
      chk_outs($sformatf("rand%0d", c), e_grant, e_bsel, e_en, e_data, e_rdy, e_nxt);
      @(posedge in_clk);
      model_step();
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
